thermostat_zone_ctrl: RTL and testbench
=======================================

// Module: thermostat_zone_ctrl
// PURPOSE
//  Multi-zone thermostat controller. Generalises single-zone combinational heat/cool/fan control to NUM_ZONES channels.
//  Adds numeric temperature vs setpoint compare with hysteresis, compressor/burner min-on and min-off protection timers,
//  and a fan run-on timer. Sits between sensor/setpoint registers and HVAC relay drivers.
// PARAMETERS
//  NUM_ZONES     4   number of independent zones
//  TEMP_W        8   width of temperature and setpoint (unsigned)
//  HYST          2   hysteresis band, same units as temp
//  MIN_ON_CYC    8   min cycles heater/aircon stays asserted once on (>=1)
//  MIN_OFF_CYC   8   lockout cycles after heater/aircon drops (>=1)
//  FAN_RUNON_CYC 4   fan run-on cycles after heater/aircon drops (0 = none)
// PORTS
//  clk       in   1                  single clock, rising edge
//  reset     in   1                  synchronous, active-high
//  mode      in   NUM_ZONES          per zone: 1=heat, 0=cool
//  temp      in   NUM_ZONES*TEMP_W   packed measured temps, zone z at [z*TEMP_W +: TEMP_W]
//  setpoint  in   NUM_ZONES*TEMP_W   packed setpoints, same packing
//  fan_on    in   NUM_ZONES          user fan request
//  heater    out  NUM_ZONES          heater drive
//  aircon    out  NUM_ZONES          aircon drive
//  fan       out  NUM_ZONES          fan drive
//  fault     out  NUM_ZONES          sensor fault (0 unless THERMOSTAT_FAULT_EN)
// BEHAVIOUR
//  - All outputs registered. On reset all outputs 0, every zone IDLE, all timers 0; no lockout follows reset.
//  - Zones are fully independent. Inputs are sampled each edge. Outputs reflect the state entered at that edge (1-cycle latency).
//  - Per-zone FSM: IDLE, HEAT, COOL, LOCKOUT. heater=(st==HEAT), aircon=(st==COOL).
//  - IDLE->HEAT: mode=1 and temp < sp_lo. IDLE->COOL: mode=0 and temp > sp_hi. Otherwise stay IDLE.
//  - Entering HEAT/COOL loads on_tmr=MIN_ON_CYC-1. It decrements each cycle to 0. Exit is permitted only when on_tmr==0.
//  - HEAT->LOCKOUT when on_tmr==0 and (temp >= setpoint or mode==0). COOL->LOCKOUT when on_tmr==0 and (temp <= setpoint or mode==1).
//  - A mode flip mid-run never cuts MIN_ON short. HEAT never goes directly to COOL or vice versa.
//  - Entering LOCKOUT loads off_tmr=MIN_OFF_CYC-1. At off_tmr==0 -> IDLE. LOCKOUT lasts exactly MIN_OFF_CYC cycles; demand is ignored.
//  - sp_lo = setpoint-HYST, saturating at 0. sp_hi = setpoint+HYST, saturating at 2^TEMP_W-1. Compute in TEMP_W+1 bits, all unsigned.
//  - Fan: fan = heater | aircon | fan_on(registered) | (runon_tmr!=0). Leaving HEAT/COOL loads runon_tmr=FAN_RUNON_CYC.
//    The fan stays on exactly FAN_RUNON_CYC cycles after heater/aircon drops, overlapping LOCKOUT.
//  - If a run-on is pending and the zone re-enters HEAT/COOL, the fan remains on without a glitch.
//  - Reset asserted mid-run forces all outputs 0 at the next edge, ignoring MIN_ON.
// CONFIGURATION
//  THERMOSTAT_FAULT_EN defined:
//    - temp == all-ones (open sensor) or all-zeros (shorted) sampled for 2 consecutive cycles sets fault[z].
//    - fault[z] is sticky until reset.
//    - While fault[z]=1 the zone is forced to LOCKOUT-then-IDLE: heater/aircon drop at the next edge regardless of MIN_ON.
//      No new HEAT/COOL entry is allowed. Fan still follows run-on and fan_on.
//  THERMOSTAT_FAULT_EN undefined: no fault logic. fault tied 0. Extreme temps are treated as ordinary values.
// STRUCTURE
//  - thermostat_pkg: typedef enum logic [1:0] {ST_IDLE, ST_HEAT, ST_COOL, ST_LOCKOUT} zone_state_t; MODE_HEAT/MODE_COOL constants.
//    Also holds the sat_sub/sat_add helper functions.
//  - Sub-module thermostat_zone: one zone FSM with its timers and fan logic. The top instantiates it NUM_ZONES times in a generate loop.
//  - Timer widths are $clog2(max(MIN_ON_CYC, MIN_OFF_CYC, FAN_RUNON_CYC)+1).
// TESTING (defaults: HYST=2, MIN_ON=8, MIN_OFF=8, RUNON=4)
//  1. z0 mode=1 sp=100 temp=97 -> heater[0]=1 and fan[0]=1 the next cycle. temp=99 -> stays on.
//     temp=100 at cycle 3 -> heater holds until cycle 8, then 0. fan stays on 4 more cycles.
//  2. After scenario 1, temp=90 during LOCKOUT -> heater[0]=0 for 8 cycles, then IDLE, then heater=1 the next cycle.
//  3. z1 mode=0 sp=70 temp=72 -> aircon stays 0. temp=73 -> aircon[1]=1. Flip mode=1 at cycle 2 -> aircon held through cycle 8.
//     Then LOCKOUT. heater never overlaps aircon.
//  4. sp=1, HYST=2, temp=0, mode=1 -> no heat (sp_lo saturates to 0). sp=255, temp=255, mode=0 -> no cool. No wrap.
//  5. All 4 zones active with different setpoints; assert reset mid-HEAT -> all outputs 0 next edge. Re-demand heats immediately (no lockout).
//  6. FAULT_EN: temp=255 for 2 cycles while HEAT -> fault=1 and heater=0 the next edge. Temp restored -> fault stays 1 until reset.

Source files
------------

// File: rtl/thermostat_pkg.sv
// Shared types and helpers for the multi-zone thermostat controller.
//   zone_state_t : per-zone FSM state encoding
//   MODE_HEAT / MODE_COOL : meaning of each mode input bit
//   sat_sub / sat_add : unsigned saturating arithmetic used to derive the
//                       hysteresis band edges (operands must fit in 32 bits)
package thermostat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAT    = 2'd1,
    ST_COOL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } zone_state_t;

  localparam logic MODE_HEAT = 1'b1;
  localparam logic MODE_COOL = 1'b0;

  // a - b, clamped at 0
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : 32'd0;
  endfunction

  // a + b, clamped at cap; one extra bit keeps the sum from wrapping
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] cap);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, cap}) ? cap : s[31:0];
  endfunction

endpackage

// File: rtl/thermostat_zone.sv
// One thermostat zone: IDLE/HEAT/COOL/LOCKOUT FSM with min-on, min-off and
// fan run-on timers. All outputs are registered (1-cycle latency).
// Optional feature macro: THERMOSTAT_FAULT_EN (open/shorted sensor detect).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   mode              : 1 = heat, 0 = cool
//   temp, setpoint    : unsigned TEMP_W-bit measured temp and setpoint
//   fan_on            : user fan request
//   heater/aircon/fan : relay drives
//   fault             : sticky sensor fault (0 when feature disabled)
module thermostat_zone
  import thermostat_pkg::*;
#(
  parameter int unsigned TEMP_W        = 8,
  parameter int unsigned HYST          = 2,
  parameter int unsigned MIN_ON_CYC    = 8,
  parameter int unsigned MIN_OFF_CYC   = 8,
  parameter int unsigned FAN_RUNON_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic              fan_on,
  output logic              heater,
  output logic              aircon,
  output logic              fan,
  output logic              fault
);

  localparam int unsigned MAX_AB = (MIN_ON_CYC > MIN_OFF_CYC) ? MIN_ON_CYC : MIN_OFF_CYC;
  localparam int unsigned MAX_C  = (MAX_AB > FAN_RUNON_CYC) ? MAX_AB : FAN_RUNON_CYC;
  localparam int unsigned TW     = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] ON_LOAD    = TW'(MIN_ON_CYC - 1);
  localparam logic [TW-1:0] OFF_LOAD   = TW'(MIN_OFF_CYC - 1);
  localparam logic [TW-1:0] RUNON_LOAD = TW'(FAN_RUNON_CYC);
  localparam logic [31:0]   TEMP_MAX   = 32'((64'd1 << TEMP_W) - 64'd1);

  zone_state_t   st, st_nxt;
  logic [TW-1:0] on_tmr, on_nxt;
  logic [TW-1:0] off_tmr, off_nxt;
  logic [TW-1:0] runon_tmr, runon_nxt;
  logic [TEMP_W-1:0] sp_lo, sp_hi;
  logic          fault_now;

  assign sp_lo = TEMP_W'(sat_sub(32'(setpoint), 32'(HYST)));
  assign sp_hi = TEMP_W'(sat_add(32'(setpoint), 32'(HYST), TEMP_MAX));

`ifdef THERMOSTAT_FAULT_EN
  logic ext, ext_prev, fault_q;

  // Rail-to-rail readings mean an open (all-ones) or shorted (all-zeros) sensor.
  assign ext       = (temp == '1) || (temp == '0);
  // Fault takes effect on the same edge that sees the second extreme sample.
  assign fault_now = fault_q | (ext & ext_prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_prev <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      ext_prev <= ext;
      fault_q  <= fault_now;
    end
  end

  assign fault = fault_q;
`else
  assign fault_now = 1'b0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    st_nxt    = st;
    on_nxt    = (on_tmr    != '0) ? on_tmr    - TW'(1) : '0;
    off_nxt   = (off_tmr   != '0) ? off_tmr   - TW'(1) : '0;
    runon_nxt = (runon_tmr != '0) ? runon_tmr - TW'(1) : '0;
    case (st)
      ST_IDLE: begin
        if (!fault_now) begin
          if (mode == MODE_HEAT && temp < sp_lo) begin
            st_nxt = ST_HEAT;
            on_nxt = ON_LOAD;
          end else if (mode == MODE_COOL && temp > sp_hi) begin
            st_nxt = ST_COOL;
            on_nxt = ON_LOAD;
          end
        end
      end
      ST_HEAT: begin
        // A fault overrides min-on; otherwise a mode flip waits for on_tmr.
        if (fault_now || (on_tmr == '0 && (temp >= setpoint || mode == MODE_COOL))) begin
          st_nxt    = ST_LOCKOUT;
          off_nxt   = OFF_LOAD;
          runon_nxt = RUNON_LOAD;
        end
      end
      ST_COOL: begin
        if (fault_now || (on_tmr == '0 && (temp <= setpoint || mode == MODE_HEAT))) begin
          st_nxt    = ST_LOCKOUT;
          off_nxt   = OFF_LOAD;
          runon_nxt = RUNON_LOAD;
        end
      end
      default: begin
        if (off_tmr == '0) st_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from next-state so they register alongside the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_IDLE;
      on_tmr    <= '0;
      off_tmr   <= '0;
      runon_tmr <= '0;
      heater    <= 1'b0;
      aircon    <= 1'b0;
      fan       <= 1'b0;
    end else begin
      st        <= st_nxt;
      on_tmr    <= on_nxt;
      off_tmr   <= off_nxt;
      runon_tmr <= runon_nxt;
      heater    <= (st_nxt == ST_HEAT);
      aircon    <= (st_nxt == ST_COOL);
      fan       <= (st_nxt == ST_HEAT) || (st_nxt == ST_COOL) || fan_on || (runon_nxt != '0);
    end
  end

endmodule

// File: rtl/thermostat_zone_ctrl.sv
// Multi-zone thermostat controller: NUM_ZONES independent thermostat_zone
// instances between sensor/setpoint registers and HVAC relay drivers.
// Optional feature macro: THERMOSTAT_FAULT_EN (per-zone sensor fault detect).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   mode[z]           : 1 = heat, 0 = cool
//   temp, setpoint    : packed, zone z at [z*TEMP_W +: TEMP_W]
//   fan_on[z]         : user fan request
//   heater/aircon/fan : per-zone relay drives (registered)
//   fault[z]          : sticky sensor fault (0 when feature disabled)
module thermostat_zone_ctrl
  import thermostat_pkg::*;
#(
  parameter int unsigned NUM_ZONES     = 4,
  parameter int unsigned TEMP_W        = 8,
  parameter int unsigned HYST          = 2,
  parameter int unsigned MIN_ON_CYC    = 8,
  parameter int unsigned MIN_OFF_CYC   = 8,
  parameter int unsigned FAN_RUNON_CYC = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_ZONES-1:0]        mode,
  input  logic [NUM_ZONES*TEMP_W-1:0] temp,
  input  logic [NUM_ZONES*TEMP_W-1:0] setpoint,
  input  logic [NUM_ZONES-1:0]        fan_on,
  output logic [NUM_ZONES-1:0]        heater,
  output logic [NUM_ZONES-1:0]        aircon,
  output logic [NUM_ZONES-1:0]        fan,
  output logic [NUM_ZONES-1:0]        fault
);

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    thermostat_zone #(
      .TEMP_W        (TEMP_W),
      .HYST          (HYST),
      .MIN_ON_CYC    (MIN_ON_CYC),
      .MIN_OFF_CYC   (MIN_OFF_CYC),
      .FAN_RUNON_CYC (FAN_RUNON_CYC)
    ) u_zone (
      .clk      (clk),
      .reset    (reset),
      .mode     (mode[z]),
      .temp     (temp[z*TEMP_W +: TEMP_W]),
      .setpoint (setpoint[z*TEMP_W +: TEMP_W]),
      .fan_on   (fan_on[z]),
      .heater   (heater[z]),
      .aircon   (aircon[z]),
      .fan      (fan[z]),
      .fault    (fault[z])
    );
  end

endmodule

// File: tb/tb_thermostat_zone_ctrl.sv
// Directed bench for thermostat_zone_ctrl at default parameters
// (HYST=2, MIN_ON=8, MIN_OFF=8, RUNON=4), default build.
module tb_thermostat_zone_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  mode;
  logic [31:0] temp;
  logic [31:0] setpoint;
  logic [3:0]  fan_on;
  logic [3:0]  heater;
  logic [3:0]  aircon;
  logic [3:0]  fan;
  logic [3:0]  fault;

  int total = 0;
  int bad   = 0;

  thermostat_zone_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .temp     (temp),
    .setpoint (setpoint),
    .fan_on   (fan_on),
    .heater   (heater),
    .aircon   (aircon),
    .fan      (fan),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are changed and outputs read here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_zone(input int z, input logic m, input logic [7:0] t, input logic [7:0] sp);
    mode[z]          = m;
    temp[z*8 +: 8]     = t;
    setpoint[z*8 +: 8] = sp;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    mode     = '0;
    temp     = '0;
    setpoint = '0;
    fan_on   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = '0; temp = '0; setpoint = '0; fan_on = '0;
    #1;
    do_reset();
    chk("rst_heater", heater, 4'h0);
    chk("rst_aircon", aircon, 4'h0);
    chk("rst_fan",    fan,    4'h0);
    chk("rst_fault",  fault,  4'h0);

    // Scenario 1: heat call, min-on hold, fan run-on
    set_zone(0, 1'b1, 8'd97, 8'd100);
    tick();                                  // E1
    chk("s1_heat_on", heater[0], 1'b1);
    chk("s1_fan_on",  fan[0],    1'b1);
    set_zone(0, 1'b1, 8'd99, 8'd100);
    tick();                                  // E2
    chk("s1_heat_e2", heater[0], 1'b1);
    set_zone(0, 1'b1, 8'd100, 8'd100);
    for (int k = 3; k <= 8; k++) begin
      tick();
      chk("s1_min_on_hold", heater[0], 1'b1);
    end
    tick();                                  // E9: into LOCKOUT
    chk("s1_heat_off", heater[0], 1'b0);
    chk("s1_fan_runon", fan[0],   1'b1);

    // Scenario 2: demand during LOCKOUT is ignored
    set_zone(0, 1'b1, 8'd90, 8'd100);
    for (int k = 10; k <= 17; k++) begin
      tick();
      chk("s2_lockout_heater", heater[0], 1'b0);
      if (k == 12) chk("s2_fan_last_runon", fan[0], 1'b1);
      if (k == 13) chk("s2_fan_runon_end",  fan[0], 1'b0);
    end
    tick();                                  // E18: IDLE -> HEAT
    chk("s2_reheat", heater[0], 1'b1);
    chk("s2_refan",  fan[0],    1'b1);

    // Scenario 3: cooling, hysteresis edge, mode flip mid-run
    do_reset();
    set_zone(1, 1'b0, 8'd72, 8'd70);
    tick();
    chk("s3_hyst_edge_a", aircon[1], 1'b0);
    tick();
    chk("s3_hyst_edge_b", aircon[1], 1'b0);
    set_zone(1, 1'b0, 8'd73, 8'd70);
    tick();                                  // E1
    chk("s3_cool_on", aircon[1], 1'b1);
    tick();                                  // E2
    chk("s3_cool_e2", aircon[1], 1'b1);
    set_zone(1, 1'b1, 8'd73, 8'd70);
    for (int k = 3; k <= 8; k++) begin
      tick();
      chk("s3_flip_hold", aircon[1], 1'b1);
      chk("s3_no_overlap", heater[1], 1'b0);
    end
    tick();                                  // E9
    chk("s3_cool_off", aircon[1], 1'b0);
    chk("s3_no_heat_after_flip", heater[1], 1'b0);
    for (int k = 10; k <= 18; k++) tick();
    chk("s3_idle_no_heat", heater[1], 1'b0);

    // User fan request follows with one cycle latency
    fan_on[2] = 1'b1;
    tick();
    chk("fan_req_on", fan, 4'b0100);
    fan_on[2] = 1'b0;
    tick();
    chk("fan_req_off", fan, 4'b0000);

    // Scenario 4: saturating band edges
    do_reset();
    set_zone(2, 1'b1, 8'd0,   8'd1);
    set_zone(3, 1'b0, 8'd255, 8'd255);
    tick();
    tick();
    chk("s4_sat_lo_no_heat", heater, 4'h0);
    chk("s4_sat_hi_no_cool", aircon, 4'h0);
    set_zone(2, 1'b1, 8'd0,   8'd3);
    set_zone(3, 1'b0, 8'd255, 8'd252);
    tick();
    chk("s4_lo_heat", heater, 4'b0100);
    chk("s4_hi_cool", aircon, 4'b1000);

    // Scenario 5: all zones active, reset mid-run, immediate re-demand
    do_reset();
    set_zone(0, 1'b1, 8'd90, 8'd100);
    set_zone(1, 1'b1, 8'd40, 8'd50);
    set_zone(2, 1'b0, 8'd70, 8'd60);
    set_zone(3, 1'b1, 8'd70, 8'd80);
    tick();
    chk("s5_heat_all",  heater, 4'b1011);
    chk("s5_cool_all",  aircon, 4'b0100);
    chk("s5_fan_all",   fan,    4'b1111);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("s5_rst_heater", heater, 4'h0);
    chk("s5_rst_aircon", aircon, 4'h0);
    chk("s5_rst_fan",    fan,    4'h0);
    reset = 1'b0;
    tick();
    chk("s5_reheat_now", heater, 4'b1011);
    chk("s5_recool_now", aircon, 4'b0100);
    chk("fault_tied_low", fault, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
